// File: rtl/spike_dispatcher.sv
`timescale 1ns/1ps
// Spike dispatcher: buffers incoming spike addresses and broadcasts them one per
// cycle to the MAC array, sequencing each timestep boundary as drain -> clear -> run.
module spike_dispatcher #(
  parameter int ADDR_W       = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              spike_valid,
  input  logic [ADDR_W-1:0] spike_addr,
  output logic              spike_ready,
  input  logic              timestep_end,
  output logic              bcast_valid,
  output logic [ADDR_W-1:0] bcast_addr,
  output logic              clear,
  output logic [15:0]       ts_count,
  output logic              ts_overrun
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CLR_W = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              bcast_valid_q, bcast_valid_d;
  logic [ADDR_W-1:0] bcast_addr_q, bcast_addr_d;
  logic              clear_q, clear_d;
  logic [15:0]       ts_count_q, ts_count_d;
  logic              ts_overrun_q, ts_overrun_d;
  logic              push, pop;

  assign spike_ready = (state_q == S_RUN) && (count_q != FULL_CNT);
  assign push        = spike_valid && spike_ready;
  assign pop         = (state_q != S_CLEAR) && (count_q != '0);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    clr_cnt_d     = clr_cnt_q;
    bcast_valid_d = pop;
    bcast_addr_d  = bcast_addr_q;
    ts_count_d    = ts_count_q;
    ts_overrun_d  = ts_overrun_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      bcast_addr_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_RUN: begin
        if (timestep_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (timestep_end) ts_overrun_d = 1'b1;
        // Wait one extra cycle after the final pop so clear never overlaps a broadcast.
        if ((count_q == '0) && !bcast_valid_q) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        if (timestep_end) ts_overrun_d = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = S_RUN;
          ts_count_d = ts_count_q + 16'd1;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase

    clear_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      clr_cnt_q     <= '0;
      bcast_valid_q <= 1'b0;
      bcast_addr_q  <= '0;
      clear_q       <= 1'b0;
      ts_count_q    <= '0;
      ts_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      clr_cnt_q     <= clr_cnt_d;
      bcast_valid_q <= bcast_valid_d;
      bcast_addr_q  <= bcast_addr_d;
      clear_q       <= clear_d;
      ts_count_q    <= ts_count_d;
      ts_overrun_q  <= ts_overrun_d;
    end
  end

  // Buffer storage carries data only; occupancy is tracked by the reset pointers.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= spike_addr;
  end

  assign bcast_valid = bcast_valid_q;
  assign bcast_addr  = bcast_addr_q;
  assign clear       = clear_q;
  assign ts_count    = ts_count_q;
  assign ts_overrun  = ts_overrun_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
`timescale 1ns/1ps
// Self-checking bench for spike_dispatcher: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_spike_dispatcher;
  localparam int ADDR_W       = 12;
  localparam int FIFO_DEPTH   = 8;
  localparam int CLEAR_CYCLES = 4;
  localparam int VW           = ADDR_W + 20;

  logic              CLK, RESET_N;
  logic              spike_valid, spike_ready, timestep_end;
  logic              bcast_valid, clear, ts_overrun;
  logic [ADDR_W-1:0] spike_addr, bcast_addr;
  logic [15:0]       ts_count;
  int checks = 0;
  int errors = 0;

  spike_dispatcher #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .spike_valid(spike_valid), .spike_addr(spike_addr),
    .spike_ready(spike_ready), .timestep_end(timestep_end), .bcast_valid(bcast_valid),
    .bcast_addr(bcast_addr), .clear(clear), .ts_count(ts_count), .ts_overrun(ts_overrun));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: phase 0=run 1=drain 2=clear, FIFO contents as a queue.
  int                m_phase;
  logic [ADDR_W-1:0] m_q[$];
  logic              m_bv;
  logic [ADDR_W-1:0] m_ba;
  int                m_clr_left;
  logic [15:0]       m_ts;
  logic              m_ovr;
  logic [ADDR_W-1:0] acc_log[$];
  logic [ADDR_W-1:0] bc_log[$];

  wire [VW-1:0] obs_vec = {spike_ready, bcast_valid, clear, ts_overrun, ts_count, bcast_addr};
  localparam logic [VW-1:0] RESET_VEC = {1'b1, 3'b000, 16'h0000, {ADDR_W{1'b0}}};

  function automatic logic [VW-1:0] exp_vec();
    logic rdy, clr;
    rdy = (m_phase == 0) && (m_q.size() < FIFO_DEPTH);
    clr = (m_phase == 2);
    return {rdy, m_bv, clr, m_ovr, m_ts, m_ba};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_bv = 1'b0; m_ba = '0;
    m_clr_left = 0; m_ts = 16'h0000; m_ovr = 1'b0;
  endtask

  task automatic model_edge(input logic sv, input logic [ADDR_W-1:0] sa, input logic te);
    int n;
    logic push, pop, prev_bv;
    n = m_q.size();
    push = sv && (m_phase == 0) && (n < FIFO_DEPTH);
    pop = (m_phase != 2) && (n > 0);
    prev_bv = m_bv;
    m_bv = pop;
    if (pop) m_ba = m_q.pop_front();
    if (push) begin m_q.push_back(sa); acc_log.push_back(sa); end
    case (m_phase)
      0: if (te) m_phase = 1;
      1: begin
        if (te) m_ovr = 1'b1;
        if (n == 0 && !prev_bv) begin m_phase = 2; m_clr_left = CLEAR_CYCLES; end
      end
      default: begin
        if (te) m_ovr = 1'b1;
        m_clr_left--;
        if (m_clr_left == 0) begin m_phase = 0; m_ts = m_ts + 16'd1; end
      end
    endcase
  endtask

  task automatic cycle(input logic sv, input logic [ADDR_W-1:0] sa, input logic te);
    spike_valid = sv; spike_addr = sa; timestep_end = te;
    model_edge(sv, sa, te);
    @(posedge CLK); #1;
    if (bcast_valid === 1'b1) bc_log.push_back(bcast_addr);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; spike_valid = 1'b0; spike_addr = '0; timestep_end = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (obs_vec !== RESET_VEC) begin
      errors++; $display("FAIL reset_hold: got %h want %h", obs_vec, RESET_VEC);
    end
    RESET_N = 1'b1;
    cycle(1'b0, '0, 1'b0);
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_single_spike();
    bc_log.delete();
    cycle(1'b1, ADDR_W'(12), 1'b0);
    checks++;
    if (bcast_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: bcast_valid got %b want 0", bcast_valid);
    end
    cycle(1'b0, '0, 1'b0);
    checks++;
    if ({bcast_valid, bcast_addr} !== {1'b1, ADDR_W'(12)}) begin
      errors++; $display("FAIL single_bcast: got %b/%0d want 1/12", bcast_valid, bcast_addr);
    end
    for (int t = 0; t < 4; t++) begin
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec() || clear !== 1'b0) begin
        errors++; $display("FAIL single_idle t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
    end
    checks++;
    if (bc_log.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d broadcasts want 1", bc_log.size());
    end
  endtask

  task automatic test_full_ordering();
    int i, guard;
    logic acc;
    bc_log.delete();
    i = 1; guard = 0;
    while (i <= 10 && guard < 100) begin
      acc = spike_ready;
      cycle(1'b1, ADDR_W'(i), 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL order_cycle g%0d: got %h want %h", guard, obs_vec, exp_vec());
      end
      if (acc) i++;
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++; $display("FAIL order_timeout: accepted %0d want 10", i - 1);
    end
    for (int t = 0; t < 6; t++) begin
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL order_tail t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
    end
    checks++;
    if (bc_log.size() != 10) begin
      errors++; $display("FAIL order_count: got %0d want 10", bc_log.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (bc_log[k] !== ADDR_W'(k + 1)) begin
          errors++; $display("FAIL order_item %0d: got %0d want %0d", k, bc_log[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_boundary_drain();
    int last_bv, first_clr, last_clr, n_clr, end_t;
    logic [15:0] ts0, ts_after;
    logic rdy_after;
    bc_log.delete();
    ts0 = m_ts; last_bv = -1; first_clr = -1; last_clr = -1; n_clr = 0; end_t = -1;
    ts_after = '0; rdy_after = 1'b0;
    for (int t = 0; t < 30; t++) begin
      cycle(t < 3, ADDR_W'(3 + t), t == 2);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL drain_cycle t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
      if (bcast_valid === 1'b1) last_bv = t;
      if (clear === 1'b1) begin
        if (first_clr < 0) first_clr = t;
        last_clr = t; n_clr++;
      end else if (n_clr > 0 && end_t < 0) begin
        end_t = t; ts_after = ts_count; rdy_after = spike_ready;
      end
    end
    checks++;
    if (bc_log.size() != 3 || bc_log[0] !== ADDR_W'(3) || bc_log[1] !== ADDR_W'(4) || bc_log[2] !== ADDR_W'(5)) begin
      errors++; $display("FAIL drain_seq: got %0d broadcasts want 3,4,5", bc_log.size());
    end
    checks++;
    if (n_clr != CLEAR_CYCLES || last_clr - first_clr + 1 != CLEAR_CYCLES) begin
      errors++; $display("FAIL drain_clear_len: got %0d span %0d want %0d", n_clr, last_clr - first_clr + 1, CLEAR_CYCLES);
    end
    checks++;
    if (first_clr <= last_bv) begin
      errors++; $display("FAIL drain_gap: clear at %0d last bcast at %0d want clear later", first_clr, last_bv);
    end
    checks++;
    if (end_t < 0 || ts_after !== ts0 + 16'd1 || rdy_after !== 1'b1) begin
      errors++; $display("FAIL drain_return: ts got %0d want %0d ready got %b want 1", ts_after, ts0 + 16'd1, rdy_after);
    end
  endtask

  task automatic test_overrun();
    int first_clr, n_clr;
    logic [15:0] ts0;
    ts0 = m_ts; first_clr = -1; n_clr = 0;
    for (int t = 0; t < 30; t++) begin
      cycle(1'b0, '0, (t == 0) || (first_clr >= 0 && t == first_clr + 1));
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL ovr_cycle t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
      if (clear === 1'b1) begin
        if (first_clr < 0) first_clr = t;
        n_clr++;
      end
    end
    checks++;
    if (ts_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b want 1", ts_overrun);
    end
    checks++;
    if (n_clr != CLEAR_CYCLES) begin
      errors++; $display("FAIL ovr_clear_len: got %0d want %0d", n_clr, CLEAR_CYCLES);
    end
    checks++;
    if (ts_count !== ts0 + 16'd1) begin
      errors++; $display("FAIL ovr_ts: got %0d want %0d", ts_count, ts0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1, ADDR_W'($urandom), t == 4);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_fill t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
    end
    spike_valid = 1'b0; timestep_end = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (obs_vec !== RESET_VEC) begin
      errors++; $display("FAIL rmid_drain_async: got %h want %h", obs_vec, RESET_VEC);
    end
    model_reset();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec() || bcast_valid !== 1'b0 || ts_count !== 16'h0000) begin
        errors++; $display("FAIL rmid_after t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
    end
    cycle(1'b0, '0, 1'b1);
    for (int t = 0; t < 10 && clear !== 1'b1; t++) cycle(1'b0, '0, 1'b0);
    checks++;
    if (clear !== 1'b1) begin
      errors++; $display("FAIL rmid_clear_reach: clear got %b want 1", clear);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (obs_vec !== RESET_VEC) begin
      errors++; $display("FAIL rmid_clear_async: got %h want %h", obs_vec, RESET_VEC);
    end
    model_reset();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL rmid_clear_after t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int bad;
    acc_log.delete(); bc_log.delete();
    for (int t = 0; t < 640; t++) begin
      if (t < 600)
        cycle(($urandom % 4) != 0, ADDR_W'($urandom), ($urandom % 25) == 0);
      else
        cycle(1'b0, '0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL random t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
    end
    bad = (acc_log.size() == bc_log.size()) ? -1 : 0;
    for (int k = 0; k < acc_log.size() && bad < 0; k++)
      if (bc_log[k] !== acc_log[k]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL random_order: broadcast %0d items first diff at %0d want %0d items in order", bc_log.size(), bad, acc_log.size());
    end
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    force dut.ts_count_q = 16'hFFFF;
    model_edge(1'b0, '0, 1'b0);
    m_ts = 16'hFFFF;
    @(posedge CLK); #1;
    release dut.ts_count_q;
    checks++;
    if (ts_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h want ffff", ts_count);
    end
    cycle(1'b0, '0, 1'b1);
    for (int t = 0; t < 20; t++) begin
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL wrap_cycle t%0d: got %h want %h", t, obs_vec, exp_vec());
      end
    end
    checks++;
    if (ts_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_result: got %h want 0000", ts_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_full_ordering();
    test_boundary_drain();
    test_overrun();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
